// File: rtl/demux8_stream_if.sv
// demux8_stream_if: producer-side and consumer-side handshake signals of the
// 1-to-2 byte demultiplexer. The slave modport is the demux itself; the master
// modport is the surrounding producer/consumers.
interface demux8_stream_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in;
  logic             in_valid;
  logic             enable;
  logic             in_ready;
  logic [WIDTH-1:0] out1;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out2;
  logic             out2_valid;
  logic             out2_ready;
  logic [15:0]      cnt1;
  logic [15:0]      cnt2;

  modport slave (
    input  in, in_valid, enable, out1_ready, out2_ready,
    output in_ready, out1, out1_valid, out2, out2_valid, cnt1, cnt2
  );

  modport master (
    output in, in_valid, enable, out1_ready, out2_ready,
    input  in_ready, out1, out1_valid, out2, out2_valid, cnt1, cnt2
  );
endinterface

// File: rtl/demux8_stream.sv
// demux8_stream: steers each accepted byte of one valid/ready stream into one
// of two small FIFOs (enable=0 -> channel 1, enable=1 -> channel 2).
// Optional macro DEMUX_STATS_EN adds 16-bit per-channel delivered-word
// counters on cnt1/cnt2; without it both counters are tied to zero.
module demux8_stream #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2   // power of two, 2..16
) (
  input logic            clk,
  input logic            reset,
  demux8_stream_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Index 0 is channel 1 (out1), index 1 is channel 2 (out2).
  logic [1:0]             full;
  logic [1:0]             empty;
  logic [1:0]             push;
  logic [1:0]             pop;
  logic [1:0]             ready;
  logic [1:0][WIDTH-1:0]  head;
  logic [1:0][15:0]       stats;
  logic                   accept_ok;

  // in_ready only looks at the selected channel and is held low while in reset.
  assign accept_ok = !reset && (bus.enable ? !full[1] : !full[0]);
  assign bus.in_ready = accept_ok;

  assign push[0] = bus.in_valid && accept_ok && !bus.enable;
  assign push[1] = bus.in_valid && accept_ok &&  bus.enable;
  assign ready   = {bus.out2_ready, bus.out1_ready};
  assign pop     = ~empty & ready;

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[ch]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[ch])  rd_ptr <= rd_ptr + 1'b1;
        case ({push[ch], pop[ch]})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end

    // Storage write at the tail; push is already suppressed during reset.
    always_ff @(posedge clk) begin
      // NOTE: the storage array is deliberately not reset; occupancy decides
      // what is visible, so stale contents are never observed.
      if (push[ch]) mem[wr_ptr] <= bus.in;
    end

    assign full[ch]  = (count == CW'(DEPTH));
    assign empty[ch] = (count == '0);
    assign head[ch]  = empty[ch] ? '0 : mem[rd_ptr];

`ifdef DEMUX_STATS_EN
    logic [15:0] delivered;

    // Delivered-word counter, wraps 0xFFFF -> 0x0000.
    always_ff @(posedge clk) begin
      if (reset)        delivered <= '0;
      else if (pop[ch]) delivered <= delivered + 16'd1;
    end

    assign stats[ch] = delivered;
`else
    assign stats[ch] = '0;
`endif
  end

  assign bus.out1       = head[0];
  assign bus.out1_valid = !empty[0];
  assign bus.out2       = head[1];
  assign bus.out2_valid = !empty[1];
  assign bus.cnt1       = stats[0];
  assign bus.cnt2       = stats[1];
endmodule

// File: doc/demux8_stream.md
Name: demux8_stream

Overview:
- 1-to-2 byte demultiplexer. It is the splitting counterpart to the 2:1 byte select mux.
- It takes one valid/ready byte stream and steers each accepted byte to one of two output channels, chosen by a per-byte select.
- Each output channel has a small FIFO, so a stalled consumer on one channel does not lose data.
- It sits between a single producer and two independent consumers in the final datapath.

Parameters:
- WIDTH, 8: data width of the input and both outputs.
- DEPTH, 2: entries per output FIFO. Must be a power of two in the range 2..16.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  WIDTH  input data byte.
- in_valid  input  1  producer has a byte on `in`.
- enable  input  1  channel select, sampled together with `in`: 0 steers to out1, 1 steers to out2.
- in_ready  output  1  block can accept the byte at the current `enable`.
- out1  output  WIDTH  channel-1 head data.
- out1_valid  output  1  channel-1 FIFO not empty.
- out1_ready  input  1  channel-1 consumer accepts the head entry.
- out2  output  WIDTH  channel-2 head data.
- out2_valid  output  1  channel-2 FIFO not empty.
- out2_ready  input  1  channel-2 consumer accepts the head entry.
- cnt1  output  16  channel-1 delivered-word count (see Optional Feature).
- cnt2  output  16  channel-2 delivered-word count (see Optional Feature).

Behaviour:
- Reset (synchronous): applies at the clk edge where reset=1.
  - Both FIFOs empty: pointers 0, occupancy 0.
  - out1_valid = out2_valid = 0.
  - out1 = out2 = 0.
  - cnt1 = cnt2 = 0.
  - Reset overrides any push or pop in the same cycle. Data held in the FIFOs at that moment is discarded.
- in_ready (combinational):
  - enable=0: in_ready = !full1.
  - enable=1: in_ready = !full2.
  - in_ready never depends on in_valid.
  - in_ready stays 0 during the reset cycle.
- Push: when in_valid && in_ready at a clk edge, `in` is written to the tail of the selected FIFO and that FIFO's occupancy increments.
  - The unselected channel is untouched.
  - Bytes on the same channel keep their order; there is no ordering relation between the two channels.
- Latency: a byte pushed at edge N appears at the head (outX_valid=1) after edge N, i.e. 1 cycle. There is no combinational path from `in` to outX.
- Pop: when outX_valid && outX_ready at a clk edge, the head entry is removed.
  - outX and outX_valid then show the next entry, or go empty.
  - outX_ready while empty is ignored.
- Head outputs: outX = mem[rd_ptr] when non-empty, and 0 when empty.
- Full/empty:
  - Occupancy width is clog2(DEPTH)+1. full = (occupancy == DEPTH); empty = (occupancy == 0).
  - Read and write pointers wrap modulo DEPTH.
- Simultaneous push and pop on the same channel:
  - Not full: both happen, occupancy unchanged, pointers both advance.
  - Full: in_ready=0, so only the pop occurs. A full FIFO does not accept a byte in the same cycle it frees a slot; there is no ready pass-through.
  - Empty: the pushed byte becomes visible next cycle only. There is no bypass.
- Channels are independent: a push to one channel can coincide with pops on both channels.
- If enable changes while in_valid=1 and in_ready=0, the byte is not yet committed. It goes to the channel selected on the accepting edge.

Optional Feature:
- Macro: DEMUX_STATS_EN.
- Defined:
  - cnt1 and cnt2 increment by 1 on each pop from channel 1 and channel 2 respectively.
  - 16-bit counters, wrapping 0xFFFF -> 0x0000.
  - Cleared by reset.
- Undefined: counter logic is absent; cnt1 and cnt2 are tied to 0.

Test Plan:
- Reset, then idle:
  - in_valid=0, out1_ready=out2_ready=1 for 5 cycles -> out1_valid=out2_valid=0, out1=out2=0, in_ready=1 for both enable values.
- Alternate steering:
  - Push 0xA1 (enable=0), 0xB2 (enable=1), 0xA3 (enable=0), with both readies=1.
  - -> out1 shows 0xA1 then 0xA3; out2 shows 0xB2. Each appears 1 cycle after its accept.
- Fill channel 1 with out1_ready=0 (DEPTH=2):
  - Push 0x11, 0x22 at enable=0 -> in_ready=0 at enable=0, while in_ready=1 at enable=1.
  - Push 0x33 at enable=1 -> accepted onto out2.
- Full plus pop in the same cycle:
  - Start with channel 1 full [0x11,0x22]; raise out1_ready=1 while in_valid=1, enable=0, in=0x44.
  - -> 0x11 popped and 0x44 not accepted that cycle. Next cycle in_ready=1, then 0x44 is accepted.
  - Final out1 order: 0x22, 0x44.
- Reset mid-operation:
  - Both FIFOs hold data; assert reset for 1 cycle together with push and pop -> all valids 0, outputs 0, counters 0. The next push after reset appears alone.
- DEMUX_STATS_EN:
  - Deliver 3 words on channel 1 and 1 word on channel 2 -> cnt1=3, cnt2=1.
  - Preload cnt1 by driving 65536 pops -> cnt1 wraps to 0.
  - Without the macro, cnt1 and cnt2 stay 0 throughout.
